hdb3_tx_ctrl: RTL and testbench

HDB3_TX_CTRL -- requirements
Module: hdb3_tx_ctrl

---
 rtl/hdb3_pkg.sv | 19 +
 rtl/hdb3_rr_arb.sv | 33 +++
 rtl/hdb3_tx_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_hdb3_tx_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdb3_pkg.sv
// hdb3_pkg: shared FSM state encoding and default timing constants for the
// HDB3 transmit controller.
package hdb3_pkg;

    // Controller phases: wait for a requester, wait for a byte, serialise,
    // pad with zeros, then hold the encoder idle between frames.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_FLUSH = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    localparam int DEF_FLUSH_BITS = 4;
    localparam int DEF_GAP_CYCLES = 8;
    localparam int DEF_TIMEOUT    = 64;

endpackage

// File: rtl/hdb3_rr_arb.sv
// hdb3_rr_arb: two-way round-robin grant with a last-granted pointer.
// The pointer resets to requester 1 so requester 0 wins the first tie.
module hdb3_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt
);

    logic ptr_q;
    logic ptr_d;

    // Winner selection: on a tie favour whoever was not granted last.
    always_comb begin
        if (req == 2'b11) begin
            gnt = ~ptr_q;
        end else begin
            gnt = req[1];
        end
        ptr_d = take ? gnt : ptr_q;
    end

    // Last-granted pointer, updated only when the grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hdb3_tx_ctrl.sv
// hdb3_tx_ctrl: arbitrates two byte-stream requesters and serialises each
// frame MSB first into an HDB3 encoder, followed by flush zeros and an idle
// gap. Define HDB3_TX_TIMEOUT_EN to enable the underrun watchdog in LOAD.
module hdb3_tx_ctrl
    import hdb3_pkg::*;
#(
    parameter int FLUSH_BITS = DEF_FLUSH_BITS,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic        enc_data,
    output logic        enc_en,
    output logic        busy,
    output logic        gnt_id,
    output logic        frame_done,
    output logic        err_timeout
);

    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_BITS - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;

    logic [1:0]  req_ready_q, req_ready_d;
    logic        enc_data_q, enc_data_d;
    logic        enc_en_q, enc_en_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;

    logic        arb_gnt;
    logic        arb_take;

`ifdef HDB3_TX_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wait_q, wait_d;
    logic        err_timeout_q, err_timeout_d;
`endif

    hdb3_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .take  (arb_take),
        .gnt   (arb_gnt)
    );

    // Next-state logic, then output decode from the next state so every
    // output leaves a flop and reflects the phase of the current cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d  = state_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        arb_take = 1'b0;
`ifdef HDB3_TX_TIMEOUT_EN
        wait_d        = wait_q;
        err_timeout_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid != 2'b00) begin
                    gnt_d    = arb_gnt;
                    arb_take = 1'b1;
                    state_d  = ST_LOAD;
`ifdef HDB3_TX_TIMEOUT_EN
                    wait_d   = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (req_valid[gnt_q]) begin
                    byte_d  = gnt_q ? req_data[15:8] : req_data[7:0];
                    last_d  = req_last[gnt_q];
                    bit_d   = 3'd0;
                    state_d = ST_SHIFT;
                end
`ifdef HDB3_TX_TIMEOUT_EN
                else if (wait_q == TIMEOUT_LAST) begin
                    err_timeout_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = ST_FLUSH;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
`endif
            end
            ST_SHIFT: begin
                if (bit_q == 3'd7) begin
                    if (last_q) begin
                        cnt_d   = '0;
                        state_d = ST_FLUSH;
                    end else if (req_valid[gnt_q]) begin
                        // Reload on the final bit keeps the stream contiguous.
                        byte_d = gnt_q ? req_data[15:8] : req_data[7:0];
                        last_d = req_last[gnt_q];
                        bit_d  = 3'd0;
                    end else begin
                        state_d = ST_LOAD;
`ifdef HDB3_TX_TIMEOUT_EN
                        wait_d  = '0;
`endif
                    end
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d       = (state_d != ST_IDLE);
        enc_en_d     = (state_d == ST_SHIFT) || (state_d == ST_FLUSH);
        enc_data_d   = (state_d == ST_SHIFT) ? byte_d[3'd7 - bit_d] : 1'b0;
        frame_done_d = (state_d == ST_GAP) && (cnt_d == GAP_LAST);
        req_ready_d  = 2'b00;
        if ((state_d == ST_LOAD) ||
            ((state_d == ST_SHIFT) && (bit_d == 3'd7) && !last_d)) begin
            req_ready_d[gnt_d] = 1'b1;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            // NOTE: the byte register is reset too, so a reset mid-frame leaves no stale data.
            state_q      <= ST_IDLE;
            bit_q        <= '0;
            cnt_q        <= '0;
            byte_q       <= '0;
            last_q       <= 1'b0;
            gnt_q        <= 1'b0;
            req_ready_q  <= '0;
            enc_data_q   <= 1'b0;
            enc_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            cnt_q        <= cnt_d;
            byte_q       <= byte_d;
            last_q       <= last_d;
            gnt_q        <= gnt_d;
            req_ready_q  <= req_ready_d;
            enc_data_q   <= enc_data_d;
            enc_en_q     <= enc_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef HDB3_TX_TIMEOUT_EN
    // Underrun watchdog counter and its abort pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q        <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wait_q        <= wait_d;
            err_timeout_q <= err_timeout_d;
        end
    end
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign req_ready  = req_ready_q;
    assign enc_data   = enc_data_q;
    assign enc_en     = enc_en_q;
    assign busy       = busy_q;
    assign gnt_id     = gnt_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hdb3_tx_ctrl.sv
// tb_hdb3_tx_ctrl: directed frames plus randomized requester traffic, checked
// every cycle against a schedule-queue model of the transmit controller.
module tb_hdb3_tx_ctrl;
    import hdb3_pkg::*;

    localparam int FB = DEF_FLUSH_BITS;
    localparam int GC = DEF_GAP_CYCLES;
`ifdef HDB3_TX_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = DEF_TIMEOUT;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_last = '0;
    logic [1:0]  req_ready;
    logic        enc_data, enc_en, busy, gnt_id, frame_done, err_timeout;

    hdb3_tx_ctrl #(.FLUSH_BITS(FB), .GAP_CYCLES(GC), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .enc_data    (enc_data),
        .enc_en      (enc_en),
        .busy        (busy),
        .gnt_id      (gnt_id),
        .frame_done  (frame_done),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a queue of scheduled cycles ----------------
    typedef struct packed {
        logic en;
        logic data;
        logic rdy;
        logic done;
        logic err;
        logic fin;
    } ent_t;

    typedef struct packed {
        logic en;
        logic data;
        logic done;
        logic err;
        logic gnt;
        logic busy;
    } rec_t;

    ent_t sched[$];
    rec_t log_q[$];
    logic busy_m  = 1'b0;
    logic gnt_m   = 1'b0;
    logic lastg_m = 1'b1;
    int   wait_m  = 0;
    int   acc_cnt = 0;
    int   done_cnt_m = 0;

    task automatic push_tail(input logic err);
        ent_t e;
        for (int i = 0; i < FB; i++) begin
            e = '0; e.en = 1'b1; e.err = err && (i == 0);
            sched.push_back(e);
        end
        for (int i = 0; i < GC; i++) begin
            e = '0; e.done = (i == GC - 1); e.fin = (i == GC - 1);
            sched.push_back(e);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l);
        ent_t e;
        for (int i = 0; i < 8; i++) begin
            e = '0; e.en = 1'b1; e.data = d[7 - i]; e.rdy = (i == 7) && !l;
            sched.push_back(e);
        end
        if (l) push_tail(1'b0);
        acc_cnt++;
    endtask

    task automatic model_reset();
        sched.delete();
        busy_m  = 1'b0;
        gnt_m   = 1'b0;
        lastg_m = 1'b1;
        wait_m  = 0;
    endtask

    // Compare the DUT against the model mid-cycle, then advance the model.
    always @(negedge clk) begin : monitor
        logic [7:0] act_o, exp_o;
        logic [1:0] rdy_m;
        ent_t h;
        rec_t r;
        act_o = {req_ready, enc_data, enc_en, busy, gnt_id, frame_done, err_timeout};
        if (!rst_n) begin
            model_reset();
            check("reset_outputs", 64'(act_o), 64'h0);
        end else begin
            h = (sched.size() > 0) ? sched[0] : '0;
            if (!busy_m) rdy_m = 2'b00;
            else if (sched.size() == 0 || h.rdy) rdy_m = gnt_m ? 2'b10 : 2'b01;
            else rdy_m = 2'b00;
            exp_o = {rdy_m, h.data, h.en, busy_m, gnt_m, h.done, h.err};
            check("cycle_outputs", 64'(act_o), 64'(exp_o));
            r = '{en: enc_en, data: enc_data, done: frame_done, err: err_timeout,
                  gnt: gnt_id, busy: busy};
            log_q.push_back(r);

            if (!busy_m) begin
                if (req_valid != 2'b00) begin
                    gnt_m   = (req_valid == 2'b11) ? ~lastg_m : req_valid[1];
                    lastg_m = gnt_m;
                    busy_m  = 1'b1;
                    wait_m  = 0;
                end
            end else if (sched.size() == 0) begin
                if (req_valid[gnt_m])
                    push_byte(gnt_m ? req_data[15:8] : req_data[7:0], req_last[gnt_m]);
`ifdef HDB3_TX_TIMEOUT_EN
                else if (wait_m == TO - 1) push_tail(1'b1);
                else wait_m++;
`endif
            end else begin
                h = sched.pop_front();
                if (h.rdy && req_valid[gnt_m])
                    push_byte(gnt_m ? req_data[15:8] : req_data[7:0], req_last[gnt_m]);
                if (h.fin) begin
                    busy_m = 1'b0;
                    done_cnt_m++;
                end
                if (sched.size() == 0) wait_m = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic offer(input logic k, input logic [7:0] d, input logic l);
        int start = acc_cnt;
        int guard = 0;
        req_valid = '0; req_valid[k] = 1'b1;
        req_data  = k ? {d, 8'h00} : {8'h00, d};
        req_last  = '0; req_last[k] = l;
        do begin
            @(posedge clk); #1; guard++;
        end while (acc_cnt == start && guard < 400);
        check("offer_accepted", 64'(acc_cnt != start), 64'h1);
        req_valid = '0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy_m && guard < 500) begin
            @(posedge clk); #1; guard++;
        end
        check("frame_completes", 64'(busy_m), 64'h0);
    endtask

    task automatic analyze(output int en_cnt, output logic [63:0] bits, output int done_cnt,
                           output int err_cnt, output int inner_gap, output int post_gap,
                           output int g0, output int g1);
        int first = -1, last = -1, starts = 0;
        en_cnt = 0; bits = '0; done_cnt = 0; err_cnt = 0; inner_gap = 0; post_gap = 0;
        g0 = -1; g1 = -1;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i].en) begin
                if (first < 0) first = i;
                last = i;
                en_cnt++;
                bits = {bits[62:0], log_q[i].data};
            end
            if (log_q[i].done) done_cnt++;
            if (log_q[i].err) err_cnt++;
            if (log_q[i].busy && (i == 0 || !log_q[i-1].busy)) begin
                if (starts == 0) g0 = int'(log_q[i].gnt);
                else if (starts == 1) g1 = int'(log_q[i].gnt);
                starts++;
            end
        end
        for (int i = first; i >= 0 && i <= last; i++) if (!log_q[i].en) inner_gap++;
        for (int i = last + 1; last >= 0 && i < log_q.size(); i++)
            if (log_q[i].busy && !log_q[i].en) post_gap++;
    endtask

    task automatic both_tie(input string tag);
        int guard = 0;
        int start = done_cnt_m;
        int en_cnt, done_cnt, err_cnt, inner_gap, post_gap, g0, g1;
        logic [63:0] bits;
        log_q.delete();
        req_valid = 2'b11; req_data = 16'h963C; req_last = 2'b11;
        while (done_cnt_m < start + 2 && guard < 600) begin
            @(posedge clk); #1; guard++;
        end
        req_valid = '0;
        check({tag, "_two_frames"}, 64'(done_cnt_m - start), 64'd2);
        analyze(en_cnt, bits, done_cnt, err_cnt, inner_gap, post_gap, g0, g1);
        check({tag, "_first_gnt"},  64'(g0), 64'd0);
        check({tag, "_second_gnt"}, 64'(g1), 64'd1);
        check({tag, "_bits"},       bits, 64'h3C0960);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int en_cnt, done_cnt, err_cnt, inner_gap, post_gap, g0, g1;
        logic [63:0] bits;
        int guard;

        #1;
        check("reset_state", 64'({req_ready, enc_data, enc_en, busy, gnt_id, frame_done, err_timeout}), 64'h0);
        do_reset();
        @(posedge clk); #1;

        // Tie straight after reset: requester 0 first, then 1.
        both_tie("tie_after_reset");

        // Single-byte frame 0xC3.
        log_q.delete();
        offer(1'b0, 8'hC3, 1'b1);
        wait_idle();
        analyze(en_cnt, bits, done_cnt, err_cnt, inner_gap, post_gap, g0, g1);
        check("c3_en_cycles", 64'(en_cnt), 64'd12);
        check("c3_bits",      bits, 64'hC30);
        check("c3_done",      64'(done_cnt), 64'd1);
        check("c3_gap",       64'(post_gap), 64'd8);

        // Two bytes back-to-back.
        log_q.delete();
        offer(1'b0, 8'hA5, 1'b0);
        offer(1'b0, 8'h0F, 1'b1);
        wait_idle();
        analyze(en_cnt, bits, done_cnt, err_cnt, inner_gap, post_gap, g0, g1);
        check("b2b_en_cycles", 64'(en_cnt), 64'd20);
        check("b2b_bits",      bits, 64'hA50F0);
        check("b2b_no_gap",    64'(inner_gap), 64'd0);

        // Second byte withheld: 5 enc_en=0 cycles between the bytes.
        log_q.delete();
        offer(1'b0, 8'hA5, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        offer(1'b0, 8'h0F, 1'b1);
        wait_idle();
        analyze(en_cnt, bits, done_cnt, err_cnt, inner_gap, post_gap, g0, g1);
        check("stall_bits",  bits, 64'hA50F0);
        check("stall_gap",   64'(inner_gap), 64'd5);
        check("stall_noerr", 64'(err_cnt), 64'd0);

`ifdef HDB3_TX_TIMEOUT_EN
        // Underrun: first byte only, then silence.
        log_q.delete();
        offer(1'b0, 8'hA5, 1'b0);
        wait_idle();
        analyze(en_cnt, bits, done_cnt, err_cnt, inner_gap, post_gap, g0, g1);
        check("to_err_pulses", 64'(err_cnt), 64'd1);
        check("to_bits",       bits, 64'hA50);
        check("to_wait",       64'(inner_gap), 64'd16);
        check("to_gap",        64'(post_gap), 64'd8);
`endif

        // Asynchronous reset while shifting.
        offer(1'b0, 8'hC3, 1'b1);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_shift",
              64'({req_ready, enc_data, enc_en, busy, gnt_id, frame_done, err_timeout}), 64'h0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        both_tie("tie_after_midreset");

        // Randomized traffic on both requesters.
        for (int c = 0; c < 2500; c++) begin
            req_valid = 2'($urandom);
            req_data  = 16'($urandom);
            req_last  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            @(posedge clk); #1;
        end

        // Drain: finish whatever frame is open, then go quiet.
        guard = 0;
        while ((busy_m || req_valid != 2'b00) && guard < 400) begin
            if (busy_m) begin
                req_valid = 2'b11; req_last = 2'b11;
            end else begin
                req_valid = 2'b00;
            end
            @(posedge clk); #1;
            guard++;
        end
        check("drain_idle", 64'(busy_m), 64'h0);
        repeat (4) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : time_limit
        #2000000;
        $display("FAIL time_limit: simulation did not reach the summary, %0d failures so far", n_fail);
        $fatal(1, "time limit");
    end

endmodule
